// File: rtl/bg_update_ctrl.sv
// Background-model update sequencer: for each pixel, read the stored background, blend in the new pixel and write it back; a seed pass copies raw pixels instead.
// Optional foreground compare outputs (fg_valid, fg_mask) exist when BG_UPDATE_FG_MASK_EN is defined.
module bg_update_ctrl #(
  parameter int NUM_PIX   = 76800,
  parameter int ADDR_W    = 17,
  parameter int NEW_SHIFT = 15,
  parameter int OLD_SHIFT = 1
`ifdef BG_UPDATE_FG_MASK_EN
  ,
  parameter logic [15:0] FG_THRESH = 16'h0800
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              seed,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [15:0]       mem_wr_data,
  output logic              busy,
  output logic              frame_done
`ifdef BG_UPDATE_FG_MASK_EN
  ,
  output logic              fg_valid,
  output logic              fg_mask
`endif
);

  // Pixel handshake: a pixel transfers on a rising edge where pix_valid and pix_ready are both 1.
  // pix_ready is registered, high only in ACCEPT, and never depends on pix_valid in the same cycle.
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_READ, S_WAIT, S_WRITE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              seed_q, seed_d;
  logic [15:0]       pix_q, pix_d;
  logic              pix_ready_q, pix_ready_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [15:0] new_sh, old_sh, blend;
  logic [16:0] sum;

  // Read data is only valid during WAIT, so the blend is formed there and registered straight into the write data.
  always_comb begin
    new_sh = pix_q >> NEW_SHIFT;
    old_sh = mem_rd_data >> OLD_SHIFT;
    sum    = {1'b0, new_sh} + {1'b0, old_sh};
    blend  = sum[16] ? 16'hFFFF : sum[15:0];
  end

`ifdef BG_UPDATE_FG_MASK_EN
  logic        fg_valid_q, fg_valid_d;
  logic        fg_mask_q, fg_mask_d;
  logic [15:0] abs_diff;

  always_comb begin
    abs_diff = (pix_q >= mem_rd_data) ? (pix_q - mem_rd_data) : (mem_rd_data - pix_q);
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    pix_d       = pix_q;
    pix_ready_d = 1'b0;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
`ifdef BG_UPDATE_FG_MASK_EN
    fg_valid_d  = 1'b0;
    fg_mask_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d      = seed;
          addr_d      = '0;
          state_d     = S_ACCEPT;
          pix_ready_d = 1'b1;
        end
      end
      S_ACCEPT: begin
        if (pix_valid && pix_ready_q) begin
          pix_d      = pix_data;
          mem_addr_d = addr_q;
          if (seed_q) begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_data_d = pix_data;
          end else begin
            state_d = S_READ;
            rd_en_d = 1'b1;
          end
        end else begin
          pix_ready_d = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d    = S_WRITE;
        wr_en_d    = 1'b1;
        mem_addr_d = addr_q;
        wr_data_d  = blend;
`ifdef BG_UPDATE_FG_MASK_EN
        fg_valid_d = 1'b1;
        fg_mask_d  = (abs_diff > FG_THRESH);
`endif
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d      = addr_q + 1'b1;
          state_d     = S_ACCEPT;
          pix_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      seed_q      <= 1'b0;
      pix_q       <= '0;
      pix_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BG_UPDATE_FG_MASK_EN
      fg_valid_q  <= 1'b0;
      fg_mask_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      pix_q       <= pix_d;
      pix_ready_q <= pix_ready_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      mem_addr_q  <= mem_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef BG_UPDATE_FG_MASK_EN
      fg_valid_q  <= fg_valid_d;
      fg_mask_q   <= fg_mask_d;
`endif
    end
  end

  assign pix_ready   = pix_ready_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
`ifdef BG_UPDATE_FG_MASK_EN
  assign fg_valid    = fg_valid_q;
  assign fg_mask     = fg_mask_q;
`endif

endmodule

// File: tb/tb_bg_update_ctrl.sv
// Bench for bg_update_ctrl: two instances (default shifts, zero shifts) share stimulus; each has its own RAM model and expected-write queue.
// Expected writes come from a frame-level model of the background array, not from the controller's sequencing.
module tb_bg_update_ctrl;
  localparam int NP = 4;
  localparam int AW = 17;
  localparam int W  = 35;  // {is_blend, fg_mask, addr, data}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, seed, pix_valid;
  logic [15:0]   pix_data;
  logic          pix_ready0, rd_en0, wr_en0, busy0, done0, fgv0, fgm0;
  logic          pix_ready1, rd_en1, wr_en1, busy1, done1, fgv1, fgm1;
  logic [AW-1:0] mem_addr0, mem_addr1;
  logic [15:0]   rd_data0, wr_data0, rd_data1, wr_data1;

  bg_update_ctrl #(.NUM_PIX(NP), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .pix_valid(pix_valid), .pix_ready(pix_ready0), .pix_data(pix_data),
    .mem_addr(mem_addr0), .mem_rd_en(rd_en0), .mem_rd_data(rd_data0),
    .mem_wr_en(wr_en0), .mem_wr_data(wr_data0), .busy(busy0), .frame_done(done0)
`ifdef BG_UPDATE_FG_MASK_EN
    , .fg_valid(fgv0), .fg_mask(fgm0)
`endif
  );

  bg_update_ctrl #(.NUM_PIX(NP), .ADDR_W(AW), .NEW_SHIFT(0), .OLD_SHIFT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .pix_valid(pix_valid), .pix_ready(pix_ready1), .pix_data(pix_data),
    .mem_addr(mem_addr1), .mem_rd_en(rd_en1), .mem_rd_data(rd_data1),
    .mem_wr_en(wr_en1), .mem_wr_data(wr_data1), .busy(busy1), .frame_done(done1)
`ifdef BG_UPDATE_FG_MASK_EN
    , .fg_valid(fgv1), .fg_mask(fgm1)
`endif
  );

`ifndef BG_UPDATE_FG_MASK_EN
  assign fgv0 = 1'b0;
  assign fgm0 = 1'b0;
  assign fgv1 = 1'b0;
  assign fgm1 = 1'b0;
`endif

  // Background RAMs: one-cycle read latency.
  logic [15:0] ram0 [NP];
  logic [15:0] ram1 [NP];
  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= ram0[mem_addr0[1:0]];
    if (wr_en0) ram0[mem_addr0[1:0]] <= wr_data0;
    if (rd_en1) rd_data1 <= ram1[mem_addr1[1:0]];
    if (wr_en1) ram1[mem_addr1[1:0]] <= wr_data1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            total = 0;
  int            bad = 0;
  logic [W-1:0]  exp_q0[$];
  logic [W-1:0]  exp_q1[$];
  logic [15:0]   ref0 [NP];
  logic [15:0]   ref1 [NP];
  logic [15:0]   pv [NP];
  logic          cur_seed = 1'b0;
  int            pix_idx = 0;
  int            done_due [2] = '{-1, -1};
  int            rd_cyc [2] = '{0, 0};
  logic [AW-1:0] rd_addr [2];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] blend_ref(input logic [15:0] nw, input logic [15:0] old,
                                            input int ns, input int os);
    int s;
    s = (int'(nw) >> ns) + (int'(old) >> os);
    return (s > 65535) ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic fg_ref(input logic [15:0] nw, input logic [15:0] old);
    int d;
    d = int'(nw) - int'(old);
    if (d < 0) d = -d;
    return d > 'h800;
  endfunction

  // Scoreboard monitor: pops one expected entry per observed write.
  task automatic mon(input int id, input logic r, input logic rd, input logic wr,
                     input logic [AW-1:0] a, input logic [15:0] wd,
                     input logic bsy, input logic dn, input logic fv, input logic fm);
    logic [W-1:0] e;
    int n;
    if (r) begin
      done_due[id] = -1;
      return;
    end
    if (rd) begin
      rd_cyc[id]  = cyc;
      rd_addr[id] = a;
      chk("read_in_seed_frame", 40'(cur_seed), 40'(0));
    end
    if (wr) begin
      n = (id == 0) ? exp_q0.size() : exp_q1.size();
      if (n == 0) chk("unexpected_write", 40'(n), 40'(1));
      else begin
        if (id == 0) e = exp_q0.pop_front();
        else e = exp_q1.pop_front();
        chk((id == 0) ? "write_addr_data_dut0" : "write_addr_data_dut1",
            40'({a, wd}), 40'(e[32:0]));
        if (e[34]) chk("read_to_write_latency", 40'({8'(cyc - rd_cyc[id]), rd_addr[id]}),
                       40'({8'd2, e[32:16]}));
`ifdef BG_UPDATE_FG_MASK_EN
        chk("fg_valid_mask", 40'({fv, fm}), 40'({e[34], e[34] & e[33]}));
`endif
        if (e[32:16] == AW'(NP - 1)) done_due[id] = cyc + 1;
      end
    end else if (fv || fm) begin
      chk("fg_outside_write", 40'({fv, fm}), 40'(0));
    end
    if (cyc == done_due[id]) chk("frame_done_and_busy", 40'({dn, bsy}), 40'(2'b10));
    else if (dn) chk("frame_done_stray", 40'(dn), 40'(0));
  endtask

  always @(negedge clk) begin
    mon(0, rst, rd_en0, wr_en0, mem_addr0, wr_data0, busy0, done0, fgv0, fgm0);
    mon(1, rst, rd_en1, wr_en1, mem_addr1, wr_data1, busy1, done1, fgv1, fgm1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] d);
    logic [15:0] r;
    logic m;
    if (cur_seed) begin
      exp_q0.push_back({2'b00, AW'(pix_idx), d});
      exp_q1.push_back({2'b00, AW'(pix_idx), d});
      ref0[pix_idx] = d;
      ref1[pix_idx] = d;
    end else begin
      r = blend_ref(d, ref0[pix_idx], 15, 1);
      m = fg_ref(d, ref0[pix_idx]);
      exp_q0.push_back({1'b1, m, AW'(pix_idx), r});
      ref0[pix_idx] = r;
      r = blend_ref(d, ref1[pix_idx], 0, 0);
      m = fg_ref(d, ref1[pix_idx]);
      exp_q1.push_back({1'b1, m, AW'(pix_idx), r});
      ref1[pix_idx] = r;
    end
    pix_idx++;
  endtask

  task automatic send_pix(input logic [15:0] d);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    while (!pix_ready0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 40'(n), 40'(0));
      pix_valid = 1'b0;
      return;
    end
    tick();
    push_exp(d);
    pix_valid = 1'b0;
    pix_data  = 16'($urandom);
  endtask

  // Idle cycles inside a frame, sometimes with a start pulse that must be ignored.
  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        seed  = ~cur_seed;
      end
      tick();
      start = 1'b0;
    end
  endtask

  task automatic start_frame(input logic s);
    start = 1'b1;
    seed  = s;
    tick();
    start    = 1'b0;
    seed     = 1'($urandom);
    cur_seed = s;
    pix_idx  = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 100) begin
      tick();
      n++;
    end
    chk("frame_end_timeout", 40'(n >= 100), 40'(0));
    tick();
    tick();
    chk("queue_drained", 40'(exp_q0.size() + exp_q1.size()), 40'(0));
  endtask

  task automatic run_frame(input logic s);
    start_frame(s);
    for (int i = 0; i < NP; i++) begin
      gap();
      send_pix(pv[i]);
    end
    wait_idle();
  endtask

  task automatic stall_check();
    int n = 0;
    while (!(pix_ready0 && pix_ready1) && n < 50) begin
      tick();
      n++;
    end
    chk("stall_ready_timeout", 40'(n >= 50), 40'(0));
    repeat (5) begin
      @(negedge clk);
      chk("stall_dut0", 40'({pix_ready0, rd_en0, wr_en0, mem_addr0}), 40'({3'b100, AW'(pix_idx - 1)}));
      chk("stall_dut1", 40'({pix_ready1, rd_en1, wr_en1, mem_addr1}), 40'({3'b100, AW'(pix_idx - 1)}));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; seed = 1'b1; pix_valid = 1'b0; pix_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs_dut0", 40'({pix_ready0, rd_en0, wr_en0, busy0, done0, mem_addr0, wr_data0}), 40'(0));
    chk("reset_outputs_dut1", 40'({pix_ready1, rd_en1, wr_en1, busy1, done1, mem_addr1, wr_data1}), 40'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    tick();
    chk("start_with_rst_ignored", 40'({busy0, busy1, pix_ready0}), 40'(0));
    tick();

    pv = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    run_frame(1'b1);
    pv = '{16'h8000, 16'hFFFF, 16'h1000, 16'h1000};
    run_frame(1'b1);

    // Blend frame with a five-cycle stall after the second pixel.
    pv = '{16'hFFFF, 16'h0002, 16'h2000, 16'h1400};
    start_frame(1'b0);
    send_pix(pv[0]);
    send_pix(pv[1]);
    stall_check();
    send_pix(pv[2]);
    send_pix(pv[3]);
    wait_idle();

    // Reset after two pixels have been written.
    start_frame(1'b0);
    send_pix(16'($urandom));
    send_pix(16'($urandom));
    for (int n = 0; n < 20 && (exp_q0.size() + exp_q1.size() != 0 || !pix_ready0); n++) tick();
    chk("writes_before_rst", 40'({exp_q0.size() + exp_q1.size(), pix_ready0}), 40'(1));
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("state_after_mid_rst", 40'({busy0, pix_ready0, wr_en0, mem_addr0}), 40'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) pv[i] = 16'($urandom);
    run_frame(1'b0);

    // Randomized frames, mostly blends, with corner pixel values mixed in.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(0, 3))
          0: pv[i] = 16'h0000;
          1: pv[i] = 16'hFFFF;
          default: pv[i] = 16'($urandom);
        endcase
      end
      run_frame($urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_update_ctrl.md
Name: bg_update_ctrl

Overview:
- Sequences background-model maintenance for the background-subtraction pipeline.
- For each incoming camera pixel it reads the stored background word from background RAM and applies the running-average blend (new >> NEW_SHIFT) + (old >> OLD_SHIFT).
- Writes the result back to the same address, walking the frame buffer one pixel at a time.
- Also supports a seed frame that loads raw pixels as the initial background.

Parameters:
- NUM_PIX, 76800, pixels per frame (320x240); address counter wraps at NUM_PIX-1
- ADDR_W, 17, background RAM address width
- NEW_SHIFT, 15, right-shift applied to the new pixel
- OLD_SHIFT, 1, right-shift applied to the stored background
- FG_THRESH, 16'h0800, foreground threshold (used only with FG_MASK_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame pass; ignored while busy
- seed  in  1  sampled with start; 1 = seed frame (raw copy), 0 = blend frame
- pix_valid  in  1  new pixel available
- pix_ready  out  1  controller accepts pixel this cycle
- pix_data  in  16  new pixel value
- mem_addr  out  ADDR_W  background RAM address
- mem_rd_en  out  1  RAM read strobe; data valid on mem_rd_data the following cycle
- mem_rd_data  in  16  RAM read data
- mem_wr_en  out  1  RAM write strobe
- mem_wr_data  out  16  RAM write data
- busy  out  1  frame pass in progress
- frame_done  out  1  one-cycle pulse after the last write of a frame

Behaviour:
- Clocking: single clock domain. rst is synchronous and active-high.
- Reset:
  - State goes to IDLE; address counter = 0; seed_r = 0.
  - All outputs 0: pix_ready, mem_rd_en, mem_wr_en, busy, frame_done, mem_addr, mem_wr_data.
- States and transitions:
  - IDLE: start=1 latches seed into seed_r, clears addr, goes to ACCEPT. Otherwise stay.
  - ACCEPT: pix_ready=1. On pix_valid & pix_ready, latch pix_data into pix_r. Next state is WRITE if seed_r, else READ. While pix_valid=0, stay in ACCEPT with no memory activity.
  - READ: mem_rd_en=1, mem_addr=addr. Go to WAIT.
  - WAIT: capture mem_rd_data into old_r. Go to WRITE.
  - WRITE: mem_wr_en=1, mem_addr=addr, mem_wr_data=result.
    - If addr==NUM_PIX-1: addr goes to 0, frame_done=1 for the next cycle, state goes to IDLE.
    - Otherwise addr++ and state goes to ACCEPT.
- Outputs are decoded from registered state and registers only; no combinational path from inputs to outputs.
- busy=1 in every state except IDLE. Its falling edge coincides with the frame_done cycle.
- Throughput:
  - Blend frame: 4 cycles per pixel minimum (ACCEPT, READ, WAIT, WRITE).
  - Seed frame: 2 cycles per pixel.
- Arithmetic (blend frame):
  - sum = {1'b0, pix_r >> NEW_SHIFT} + {1'b0, old_r >> OLD_SHIFT}, computed in 17 bits.
  - result = sum[16] ? 16'hFFFF : sum[15:0] (saturating).
  - Seed frame: result = pix_r unmodified.
- Boundary conditions:
  - start while busy: ignored; seed_r unchanged.
  - start and rst in the same cycle: rst wins.
  - rst mid-frame: no further writes; next start restarts at addr 0.
  - A write already issued in the same cycle as rst is not retracted.
  - mem_addr holds its last value when no strobe is active.

Optional Feature:
- Macro: BG_UPDATE_FG_MASK_EN
- When defined, two extra outputs are added:
  - fg_valid (out 1): 1 only in WRITE of a blend frame.
  - fg_mask (out 1): 1 when |pix_r - old_r| > FG_THRESH, with the difference computed as an unsigned 16-bit absolute value.
- Both outputs reset to 0. Both are 0 throughout seed frames.
- When undefined, these ports and the compare logic do not exist, and all other behaviour is identical.

Test Plan:
- Reset (NUM_PIX=4): hold rst 3 cycles -> all outputs 0, state IDLE. start asserted with rst -> busy stays 0.
- Seed frame: start with seed=1; pixels 16'h1000, 16'h2000, 16'h3000, 16'h4000 -> writes addr 0..3 with exactly those values, no mem_rd_en. frame_done pulses once, one cycle after the addr 3 write. busy drops the same cycle.
- Blend frame, defaults: RAM addr 0 holds 16'h8000, pixel 16'hFFFF -> mem_rd_en at addr 0, then a write two cycles later with mem_wr_data = 16'h4001.
- Stall: pix_valid low 5 cycles mid-frame -> pix_ready stays 1, no rd/wr strobes, addr unchanged. Processing resumes on the next valid.
- Saturation, NEW_SHIFT=0 and OLD_SHIFT=0: old 16'hFFFF, new 16'h0002 -> mem_wr_data = 16'hFFFF.
- rst after 2 pixels written, then new start -> no write to addr 2 before rst. Restart writes addr 0 first.
- FG_MASK_EN (BG_UPDATE_FG_MASK_EN defined): old 16'h1000, new 16'h2000, FG_THRESH 16'h0800 -> fg_valid=1 and fg_mask=1 in WRITE. With new 16'h1400 -> fg_mask=0.
